memory_buffer_pingpong: RTL and testbench

// - Next-gen operand buffer between on-chip RAM and a row/column of processors in the sum-stationary array.
// - Two banks (ping-pong): the next instruction's RAM fetch overlaps the current instruction's broadcast/repeat phase.
// - Streams N-wide vectors to NUM_PROC processors, repeating each loaded block `repeats` times, with `last` on the final vector.

---
 rtl/memory_buffer_pkg.sv | 22 ++
 rtl/membuf_bank.sv | 90 +++++++++
 rtl/memory_buffer_pingpong.sv | 166 ++++++++++++++++
 tb/tb_memory_buffer_pingpong.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_buffer_pkg.sv
// Shared types and derived-width helpers for the ping-pong operand buffer.
// Optional feature macro: MEMBUF_PARALLEL_BROADCAST_EN (see memory_buffer_pingpong).
package memory_buffer_pkg;

  typedef enum logic {
    EMPTY   = 1'b0,
    FILLING = 1'b1
  } bank_state_e;

  function automatic int len_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int fill_w(input int depth, input int n);
    return $clog2(depth * n + 1);
  endfunction

  function automatic int id_w(input int num_proc);
    return (num_proc > 1) ? $clog2(num_proc) : 1;
  endfunction

endpackage

// File: rtl/membuf_bank.sv
// One operand bank: DEPTH*N element storage, fill counter, latched instruction
// fields and an EMPTY/FILLING state machine.
module membuf_bank
  import memory_buffer_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int N             = 4,
  parameter int DEPTH         = 16,
  parameter int PAR           = 4,
  parameter int ADDR_WIDTH    = 32,
  parameter int REPEATS_WIDTH = 8,
  localparam int LEN_W        = len_w(DEPTH),
  localparam int FILL_W       = fill_w(DEPTH, N)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_accept,
  input  logic [ADDR_WIDTH-1:0]    i_addr,
  input  logic [LEN_W-1:0]         i_len,
  input  logic [REPEATS_WIDTH-1:0] i_repeats,
  input  logic                     i_wr,
  input  logic [DATA_WIDTH-1:0]    i_wr_data [PAR],
  input  logic                     i_release,
  input  logic [LEN_W-1:0]         i_rd_vec,
  output logic [DATA_WIDTH-1:0]    o_rd_data [N],
  output logic                     o_state,
  output logic [FILL_W-1:0]        o_fill_count,
  output logic                     o_mem_ready,
  output logic [LEN_W-1:0]         o_len,
  output logic [REPEATS_WIDTH-1:0] o_repeats,
  output logic [ADDR_WIDTH-1:0]    o_mem_address
);

  localparam int MEM_WORDS = DEPTH * N;
  localparam int MEM_AW    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  bank_state_e              r_state;
  logic [FILL_W-1:0]        r_fill_count;
  logic [ADDR_WIDTH-1:0]    r_addr;
  logic [LEN_W-1:0]         r_len;
  logic [REPEATS_WIDTH-1:0] r_repeats;
  logic [DATA_WIDTH-1:0]    r_mem [MEM_WORDS];

  logic [FILL_W-1:0] w_fill_target;
  logic [MEM_AW-1:0] w_wr_base;
  logic [MEM_AW-1:0] w_rd_base;

  assign w_fill_target = FILL_W'(r_len) * FILL_W'(N);
  assign w_wr_base     = r_fill_count[MEM_AW-1:0];
  assign w_rd_base     = MEM_AW'(i_rd_vec) * MEM_AW'(N);

  // Accept always wins: the top never releases and re-arms the same bank in one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= EMPTY;
      r_fill_count <= '0;
      r_addr       <= '0;
      r_len        <= '0;
      r_repeats    <= '0;
    end else if (i_accept) begin
      r_state      <= FILLING;
      r_fill_count <= '0;
      r_addr       <= i_addr;
      r_len        <= i_len;
      r_repeats    <= i_repeats;
    end else begin
      if (i_wr) r_fill_count <= r_fill_count + FILL_W'(PAR);
      if (i_release) r_state <= EMPTY;
    end
  end

  // Payload storage carries no reset; contents are only read once written.
  always_ff @(posedge clk) begin
    if (i_wr) begin
      for (int k = 0; k < PAR; k++) r_mem[w_wr_base + MEM_AW'(k)] <= i_wr_data[k];
    end
  end

  always_comb begin
    for (int k = 0; k < N; k++) o_rd_data[k] = r_mem[w_rd_base + MEM_AW'(k)];
  end

  assign o_state       = r_state;
  assign o_fill_count  = r_fill_count;
  assign o_mem_ready   = (r_state == FILLING) && (r_fill_count < w_fill_target);
  assign o_len         = r_len;
  assign o_repeats     = r_repeats;
  assign o_mem_address = r_addr + ADDR_WIDTH'(r_fill_count);

endmodule

// File: rtl/memory_buffer_pingpong.sv
// Ping-pong operand buffer: RAM fetch into one bank overlaps broadcast/repeat of the other.
// MEMBUF_PARALLEL_BROADCAST_EN: present each vector to all processors at once instead of round-robin.
module memory_buffer_pingpong
  import memory_buffer_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int N             = 4,
  parameter int DEPTH         = 16,
  parameter int NUM_PROC      = 4,
  parameter int PAR           = 4,
  parameter int ADDR_WIDTH    = 32,
  parameter int REPEATS_WIDTH = 8,
  localparam int LEN_W        = len_w(DEPTH),
  localparam int FILL_W       = fill_w(DEPTH, N),
  localparam int ID_W         = id_w(NUM_PROC)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     instruction_valid,
  output logic                     instruction_ready,
  input  logic [ADDR_WIDTH-1:0]    address_input,
  input  logic [LEN_W-1:0]         length_input,
  input  logic [REPEATS_WIDTH-1:0] repeats_input,
  output logic [ADDR_WIDTH-1:0]    memory_address,
  input  logic [DATA_WIDTH-1:0]    memory_data [PAR],
  input  logic                     memory_read_valid,
  output logic                     memory_read_ready,
  output logic                     processor_input_valid,
  input  logic [NUM_PROC-1:0]      processor_input_ready,
  output logic [ID_W-1:0]          processor_input_id,
  output logic [DATA_WIDTH-1:0]    processor_input_data [N],
  output logic                     last
);

  // Every interface transfers on a cycle where valid && ready; the producer holds payload until then.

  if (N % PAR != 0) begin : g_par_check
    $error("memory_buffer_pingpong: N must be a multiple of PAR");
  end

  localparam int VN_W = FILL_W + 1;

  logic                     r_fill_sel;
  logic                     r_drain_sel;
  logic [LEN_W-1:0]         r_vec;
  logic [ID_W-1:0]          r_id;
  logic [REPEATS_WIDTH-1:0] r_rep_done;

  logic [1:0]               w_filling;
  logic [1:0]               w_mem_ready;
  logic [1:0]               w_accept;
  logic [1:0]               w_wr;
  logic [1:0]               w_release;
  logic [FILL_W-1:0]        w_fill_count [2];
  logic [LEN_W-1:0]         w_len [2];
  logic [REPEATS_WIDTH-1:0] w_repeats [2];
  logic [ADDR_WIDTH-1:0]    w_mem_address [2];
  logic [DATA_WIDTH-1:0]    w_rd_data0 [N];
  logic [DATA_WIDTH-1:0]    w_rd_data1 [N];

  logic            w_ram_sel;
  logic            w_take;
  logic            w_use;
  logic            w_drain_filling;
  logic [VN_W-1:0] w_vec_need;
  logic            w_fire;
  logic            w_vec_done;
  logic            w_last;
  logic            w_final_rep;

  membuf_bank #(
    .DATA_WIDTH(DATA_WIDTH), .N(N), .DEPTH(DEPTH), .PAR(PAR),
    .ADDR_WIDTH(ADDR_WIDTH), .REPEATS_WIDTH(REPEATS_WIDTH)
  ) u_bank0 (
    .clk(clk), .reset(reset),
    .i_accept(w_accept[0]), .i_addr(address_input), .i_len(length_input),
    .i_repeats(repeats_input), .i_wr(w_wr[0]), .i_wr_data(memory_data),
    .i_release(w_release[0]), .i_rd_vec(r_vec), .o_rd_data(w_rd_data0),
    .o_state(w_filling[0]), .o_fill_count(w_fill_count[0]), .o_mem_ready(w_mem_ready[0]),
    .o_len(w_len[0]), .o_repeats(w_repeats[0]), .o_mem_address(w_mem_address[0])
  );

  membuf_bank #(
    .DATA_WIDTH(DATA_WIDTH), .N(N), .DEPTH(DEPTH), .PAR(PAR),
    .ADDR_WIDTH(ADDR_WIDTH), .REPEATS_WIDTH(REPEATS_WIDTH)
  ) u_bank1 (
    .clk(clk), .reset(reset),
    .i_accept(w_accept[1]), .i_addr(address_input), .i_len(length_input),
    .i_repeats(repeats_input), .i_wr(w_wr[1]), .i_wr_data(memory_data),
    .i_release(w_release[1]), .i_rd_vec(r_vec), .o_rd_data(w_rd_data1),
    .o_state(w_filling[1]), .o_fill_count(w_fill_count[1]), .o_mem_ready(w_mem_ready[1]),
    .o_len(w_len[1]), .o_repeats(w_repeats[1]), .o_mem_address(w_mem_address[1])
  );

  // Instruction side: only the fill bank's registered state gates acceptance.
  assign instruction_ready = !w_filling[r_fill_sel];
  assign w_take            = instruction_valid && instruction_ready;
  assign w_use             = w_take && (length_input != '0) && (repeats_input != '0);
  assign w_accept[0]       = w_use && !r_fill_sel;
  assign w_accept[1]       = w_use && r_fill_sel;

  // RAM side: the older (draining) bank finishes its fetch before the newer one starts.
  assign w_ram_sel         = w_mem_ready[r_drain_sel] ? r_drain_sel : !r_drain_sel;
  assign memory_read_ready = w_mem_ready[w_ram_sel];
  assign memory_address    = w_mem_address[w_ram_sel];
  assign w_wr[0]           = memory_read_valid && memory_read_ready && !w_ram_sel;
  assign w_wr[1]           = memory_read_valid && memory_read_ready && w_ram_sel;

  // Cut-through: a vector is offered as soon as all of its elements have landed.
  assign w_drain_filling       = w_filling[r_drain_sel];
  assign w_vec_need            = VN_W'(r_vec) * VN_W'(N) + VN_W'(N);
  assign processor_input_valid = w_drain_filling &&
                                 ({1'b0, w_fill_count[r_drain_sel]} >= w_vec_need);
  assign processor_input_id    = r_id;
  assign w_last      = w_drain_filling && (r_vec == w_len[r_drain_sel] - LEN_W'(1));
  assign w_final_rep = (r_rep_done == w_repeats[r_drain_sel] - REPEATS_WIDTH'(1));

`ifdef MEMBUF_PARALLEL_BROADCAST_EN
  assign w_fire     = processor_input_valid && (&processor_input_ready);
  assign w_vec_done = w_fire;
`else
  assign w_fire     = processor_input_valid && processor_input_ready[r_id];
  assign w_vec_done = w_fire && (r_id == ID_W'(NUM_PROC - 1));
`endif

  assign last         = w_last;
  assign w_release[0] = w_vec_done && w_last && w_final_rep && !r_drain_sel;
  assign w_release[1] = w_vec_done && w_last && w_final_rep && r_drain_sel;

  always_comb begin
    for (int k = 0; k < N; k++) begin
      processor_input_data[k] = r_drain_sel ? w_rd_data1[k] : w_rd_data0[k];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fill_sel  <= 1'b0;
      r_drain_sel <= 1'b0;
      r_vec       <= '0;
      r_id        <= '0;
      r_rep_done  <= '0;
    end else begin
      if (w_use) r_fill_sel <= !r_fill_sel;
`ifdef MEMBUF_PARALLEL_BROADCAST_EN
      r_id <= '0;
`else
      if (w_fire) r_id <= (r_id == ID_W'(NUM_PROC - 1)) ? '0 : r_id + ID_W'(1);
`endif
      if (w_vec_done) begin
        if (w_last) begin
          r_vec <= '0;
          if (w_final_rep) begin
            r_rep_done  <= '0;
            r_drain_sel <= !r_drain_sel;
          end else begin
            r_rep_done <= r_rep_done + REPEATS_WIDTH'(1);
          end
        end else begin
          r_vec <= r_vec + LEN_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_memory_buffer_pingpong.sv
// Directed bench for memory_buffer_pingpong; honours MEMBUF_PARALLEL_BROADCAST_EN when defined.
module tb_memory_buffer_pingpong;

  localparam int DW    = 8;
  localparam int N     = 4;
  localparam int DEPTH = 16;
  localparam int NP    = 4;
  localparam int PAR   = 4;
  localparam int AW    = 32;
  localparam int RW    = 8;
  localparam int LEN_W = 5;
  localparam int ID_W  = 2;
  localparam int VW    = DW * N + ID_W + 1;
`ifdef MEMBUF_PARALLEL_BROADCAST_EN
  localparam int NIDS = 1;
`else
  localparam int NIDS = NP;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic            clk = 1'b0;
  logic            reset;
  logic            instruction_valid;
  logic            instruction_ready;
  logic [AW-1:0]   address_input;
  logic [LEN_W-1:0] length_input;
  logic [RW-1:0]   repeats_input;
  logic [AW-1:0]   memory_address;
  logic [DW-1:0]   memory_data [PAR];
  logic            memory_read_valid;
  logic            memory_read_ready;
  logic            processor_input_valid;
  logic [NP-1:0]   processor_input_ready;
  logic [ID_W-1:0] processor_input_id;
  logic [DW-1:0]   processor_input_data [N];
  logic            last;

  always #5 clk = ~clk;

  memory_buffer_pingpong dut (
    .clk(clk), .reset(reset),
    .instruction_valid(instruction_valid), .instruction_ready(instruction_ready),
    .address_input(address_input), .length_input(length_input), .repeats_input(repeats_input),
    .memory_address(memory_address), .memory_data(memory_data),
    .memory_read_valid(memory_read_valid), .memory_read_ready(memory_read_ready),
    .processor_input_valid(processor_input_valid), .processor_input_ready(processor_input_ready),
    .processor_input_id(processor_input_id), .processor_input_data(processor_input_data),
    .last(last)
  );

  function automatic logic [DW-1:0] ram_fn(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h3C;
  endfunction

  always_comb begin
    for (int k = 0; k < PAR; k++) memory_data[k] = ram_fn(memory_address + AW'(k));
  end

  // ---------------- scoreboard ----------------
  logic [VW-1:0] exp_q[$];
  logic [AW-1:0] addr_q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int fires = 0;
  int bubbles = 0;
  int first_fire = 0;
  int last_fire = 0;
  int acc_cyc = 0;
  bit started = 0;

  logic            rst_drv;
  logic            rand_rdy;
  logic            rand_mem;
  logic            pend;
  logic [AW-1:0]   p_addr;
  logic [LEN_W-1:0] p_len;
  logic [RW-1:0]   p_rep;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] make_exp(input logic [AW-1:0] a, input int v, input int id,
                                             input bit lst);
    logic [VW-1:0] e;
    e = '0;
    for (int k = 0; k < N; k++) e[ID_W + 1 + k * DW +: DW] = ram_fn(a + AW'(v * N + k));
    e[ID_W:1] = ID_W'(id);
    e[0] = lst;
    return e;
  endfunction

  task automatic push_expect(input logic [AW-1:0] a, input int len, input int rep);
    if (len == 0 || rep == 0) return;
    for (int b = 0; b < len * N / PAR; b++) addr_q.push_back(a + AW'(b * PAR));
    for (int r = 0; r < rep; r++)
      for (int v = 0; v < len; v++)
        for (int id = 0; id < NIDS; id++) exp_q.push_back(make_exp(a, v, id, v == len - 1));
  endtask

  // ---------------- driver ----------------
  task automatic tick();
    logic fire;
    logic [VW-1:0] got;
    @(negedge clk);
    cyc++;
    reset = rst_drv;
    processor_input_ready = rand_rdy ? NP'($urandom_range(0, (1 << NP) - 1)) : '1;
    memory_read_valid = rand_mem ? ($urandom_range(0, 2) != 0) : 1'b1;
    instruction_valid = pend;
    address_input = p_addr;
    length_input = p_len;
    repeats_input = p_rep;
    #1;
    if (!rst_drv) begin
      if (instruction_valid && instruction_ready) begin
        pend = 1'b0;
        acc_cyc = cyc;
        push_expect(p_addr, int'(p_len), int'(p_rep));
      end
      if (memory_read_valid && memory_read_ready) begin
        check("ram_beat_expected", addr_q.size() != 0, 1);
        if (addr_q.size() != 0) check("ram_addr", memory_address, addr_q.pop_front());
      end
`ifdef MEMBUF_PARALLEL_BROADCAST_EN
      fire = processor_input_valid && (&processor_input_ready);
`else
      fire = processor_input_valid && processor_input_ready[processor_input_id];
`endif
      if (fire) begin
        got = '0;
        for (int k = 0; k < N; k++) got[ID_W + 1 + k * DW +: DW] = processor_input_data[k];
        got[ID_W:1] = processor_input_id;
        got[0] = last;
        check("out_beat_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("out_vec", got, exp_q.pop_front());
        if (!started) first_fire = cyc;
        last_fire = cyc;
        started = 1;
        fires++;
      end else if (started && exp_q.size() != 0 && !rand_rdy) begin
        bubbles++;
      end
    end
  endtask

  task automatic send(input logic [AW-1:0] a, input int l, input int r);
    int n;
    n = 0;
    p_addr = a;
    p_len = LEN_W'(l);
    p_rep = RW'(r);
    pend = 1'b1;
    while (pend && n < 400) begin
      tick();
      n++;
    end
    check("instr_accept", pend, 0);
  endtask

  task automatic run_done(input string tag, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || addr_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check(tag, exp_q.size() + addr_q.size(), 0);
  endtask

  task automatic window();
    started = 0;
    bubbles = 0;
    fires = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    reset = 1'b1; rst_drv = 1'b1; rand_rdy = 1'b0; rand_mem = 1'b0; pend = 1'b0;
    p_addr = '0; p_len = '0; p_rep = '0;
    instruction_valid = 1'b0; address_input = '0; length_input = '0; repeats_input = '0;
    memory_read_valid = 1'b0; processor_input_ready = '0;
    repeat (3) tick();
    check("rst_instr_ready", instruction_ready, 1);
    check("rst_mem_ready", memory_read_ready, 0);
    check("rst_mem_addr", memory_address, 0);
    check("rst_valid", processor_input_valid, 0);
    check("rst_id", processor_input_id, 0);
    check("rst_last", last, 0);
    rst_drv = 1'b0;
    tick();

    // single instruction, two vectors
    window();
    send(32'h100, 2, 1);
    run_done("t1_drain", 100);
    check("t1_latency", first_fire - acc_cyc, 2);
    check("t1_count", fires, 2 * NIDS);
    tick();
    check("t1_ready_after", instruction_ready, 1);

    // three repeats, no bubbles between them
    window();
    send(32'h200, 4, 3);
    run_done("t2_drain", 300);
    check("t2_bubbles", bubbles, 0);
    check("t2_span", last_fire - first_fire, 4 * 3 * NIDS - 1);
    tick();

    // back-to-back instructions, third waits for a free bank
    window();
    send(32'h300, 2, 2);
    send(32'h340, 2, 1);
    tick();
    check("t3_both_busy", instruction_ready, 0);
    send(32'h380, 2, 1);
    run_done("t3_drain", 300);
    check("t3_bubbles", bubbles, 0);
    check("t3_span", last_fire - first_fire, (2 * 2 + 2 + 2) * NIDS - 1);
    tick();

    // random stalls on both sides, address wrap
    window();
    rand_rdy = 1'b1; rand_mem = 1'b1;
    send(32'h1000, 3, 2);
    send(32'h2010, 16, 1);
    send(32'hFFFF_FFF8, 4, 2);
    run_done("t4_drain", 3000);
    check("t4_count", fires, (3 * 2 + 16 + 4 * 2) * NIDS);
    rand_rdy = 1'b0; rand_mem = 1'b0;
    tick();

    // reset in the middle of the second repeat
    window();
    send(32'h400, 2, 3);
    n = 0;
    while (fires < 2 * NIDS + NIDS - 1 && n < 200) begin
      tick();
      n++;
    end
    check("t5_reached_rep2", fires, 2 * NIDS + NIDS - 1);
    rst_drv = 1'b1;
    tick();
    rst_drv = 1'b0;
    exp_q.delete();
    addr_q.delete();
    pend = 1'b0;
    tick();
    check("t5_valid_after_rst", processor_input_valid, 0);
    check("t5_ready_after_rst", instruction_ready, 1);
    check("t5_memrdy_after_rst", memory_read_ready, 0);
    check("t5_id_after_rst", processor_input_id, 0);
    window();
    send(32'h500, 1, 2);
    run_done("t5_new_drain", 100);
    check("t5_new_count", fires, 2 * NIDS);
    tick();

    // zero length / zero repeats are swallowed
    window();
    send(32'h600, 0, 2);
    repeat (3) tick();
    check("t6_len0_memrdy", memory_read_ready, 0);
    check("t6_len0_valid", processor_input_valid, 0);
    check("t6_len0_ready", instruction_ready, 1);
    send(32'h640, 2, 0);
    repeat (3) tick();
    check("t6_rep0_memrdy", memory_read_ready, 0);
    check("t6_rep0_valid", processor_input_valid, 0);
    check("t6_zero_fires", fires, 0);
    send(32'h700, 1, 1);
    run_done("t6_after_drain", 100);
    check("t6_after_count", fires, NIDS);
    repeat (2) tick();

    check("leftover", exp_q.size() + addr_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
